// File: rtl/rps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rps_pkg
//  Description : Shared types and the round-judging function for the
//                rock-paper-scissors round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rps_pkg;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      ROCK     = 2'd1,
      PAPER    = 2'd2,
      SCISSORS = 2'd3
   } move_t;

   typedef enum logic [1:0] {
      TIE = 2'd0,
      P1  = 2'd1,
      P2  = 2'd2
   } outcome_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COUNT   = 3'd1,
      CAPTURE = 3'd2,
      JUDGE   = 3'd3,
      SHOW    = 3'd4,
      DONE    = 3'd5
   } state_t;

   // First countdown value shown when a round starts.
   localparam logic [1:0] c_cd_start = 2'd3;

   // Decide one round. A missing move forfeits to the player who did move;
   // two missing moves, or two equal moves, are a tie.
   function automatic outcome_t judge(input move_t a, input move_t b);
      outcome_t res;
      if (a == b)
         res = TIE;
      else if (b == NONE)
         res = P1;
      else if (a == NONE)
         res = P2;
      else if ((a == ROCK     && b == SCISSORS) ||
               (a == SCISSORS && b == PAPER)    ||
               (a == PAPER    && b == ROCK))
         res = P1;
      else
         res = P2;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rps_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rps_round_ctrl_if
//  Description : Player-input, timer and display signals of the round
//                sequencer. The master side is the sequencer itself; the
//                slave side is the surrounding input/timer/display logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rps_round_ctrl_if #(
   parameter int WIDTH = 8
);
   import rps_pkg::*;

   logic             start;
   logic             p1_valid;
   move_t            p1_move;
   logic             p2_valid;
   move_t            p2_move;
   logic             hit_target;
   logic             tmr_run;
   logic [WIDTH-1:0] tmr_target;
   state_t           state;
   logic [1:0]       countdown;
   move_t            p1_move_q;
   move_t            p2_move_q;
   outcome_t         round_result;
   logic             result_valid;
   logic [2:0]       p1_score;
   logic [2:0]       p2_score;
   logic             match_over;
   outcome_t         match_winner;

   modport master (
      input  start, p1_valid, p1_move, p2_valid, p2_move, hit_target,
      output tmr_run, tmr_target, state, countdown, p1_move_q, p2_move_q,
             round_result, result_valid, p1_score, p2_score,
             match_over, match_winner
   );

   modport slave (
      output start, p1_valid, p1_move, p2_valid, p2_move, hit_target,
      input  tmr_run, tmr_target, state, countdown, p1_move_q, p2_move_q,
             round_result, result_valid, p1_score, p2_score,
             match_over, match_winner
   );

endinterface
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : Shared phase timer. Counts while `in` is high; once the
//                count reaches `target` it raises and holds hit_target until
//                `in` drops, which clears both count and hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             in,
   input  wire logic [WIDTH-1:0] target,
   output logic                  hit_target
);

   logic [WIDTH-1:0] r_count;
   logic             r_hit;

   // Count up while enabled, freeze and flag on reaching the target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_hit   <= 1'b0;
      end else if (!in) begin
         r_count <= '0;
         r_hit   <= 1'b0;
      end else if (r_count == target) begin
         r_hit   <= 1'b1;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign hit_target = r_hit;

endmodule
`default_nettype wire

// File: rtl/rps_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rps_round_ctrl
//  Description : Round sequencer for rock-paper-scissors. Drives one shared
//                timer through countdown, capture window and result display,
//                latches moves, judges rounds, keeps score and ends the match.
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_round_ctrl
   import rps_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int COUNT_TICKS   = 50,
   parameter int WINDOW_TICKS  = 200,
   parameter int RESULT_TICKS  = 100,
   parameter int ROUNDS_TO_WIN = 3
) (
   input wire logic         clk,
   input wire logic         reset,
   rps_round_ctrl_if.master bus
);

   localparam logic [WIDTH-1:0] c_count_tgt  = WIDTH'(COUNT_TICKS - 1);
   localparam logic [WIDTH-1:0] c_window_tgt = WIDTH'(WINDOW_TICKS - 1);
   localparam logic [WIDTH-1:0] c_result_tgt = WIDTH'(RESULT_TICKS - 1);
   localparam logic [2:0]       c_win        = 3'(ROUNDS_TO_WIN);

   state_t           r_state,        w_state;
   logic             r_gap,          w_gap;
   logic [1:0]       r_countdown,    w_countdown;
   move_t            r_p1_move,      w_p1_move;
   move_t            r_p2_move,      w_p2_move;
   outcome_t         r_result,       w_result;
   logic [2:0]       r_p1_score,     w_p1_score;
   logic [2:0]       r_p2_score,     w_p2_score;
   logic             r_tmr_run,      w_tmr_run;
   logic [WIDTH-1:0] r_tmr_target,   w_tmr_target;
   logic             r_result_valid, w_result_valid;
   logic             r_match_over,   w_match_over;
   outcome_t         r_winner,       w_winner;

   // A hit only counts while the timer is running; in the GAP cycle the
   // timer output is still stale-high and must be ignored.
   logic     w_hit;
   logic     w_p1_take;
   logic     w_p2_take;
   outcome_t w_outcome;

   assign w_hit     = bus.hit_target && r_tmr_run;
   assign w_p1_take = bus.p1_valid && (bus.p1_move != NONE) && (r_p1_move == NONE);
   assign w_p2_take = bus.p2_valid && (bus.p2_move != NONE) && (r_p2_move == NONE);
   assign w_outcome = judge(r_p1_move, r_p2_move);

   // State and every output register; outputs come straight from here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_gap          <= 1'b0;
         r_countdown    <= 2'd0;
         r_p1_move      <= NONE;
         r_p2_move      <= NONE;
         r_result       <= TIE;
         r_p1_score     <= 3'd0;
         r_p2_score     <= 3'd0;
         r_tmr_run      <= 1'b0;
         r_tmr_target   <= '0;
         r_result_valid <= 1'b0;
         r_match_over   <= 1'b0;
         r_winner       <= TIE;
      end else begin
         r_state        <= w_state;
         r_gap          <= w_gap;
         r_countdown    <= w_countdown;
         r_p1_move      <= w_p1_move;
         r_p2_move      <= w_p2_move;
         r_result       <= w_result;
         r_p1_score     <= w_p1_score;
         r_p2_score     <= w_p2_score;
         r_tmr_run      <= w_tmr_run;
         r_tmr_target   <= w_tmr_target;
         r_result_valid <= w_result_valid;
         r_match_over   <= w_match_over;
         r_winner       <= w_winner;
      end
   end

   // Next-state and next-output decode. A timed phase ends by dropping
   // tmr_run for one GAP cycle; the follow-on action happens as GAP ends.
   always_comb begin
      w_state        = r_state;
      w_gap          = 1'b0;
      w_countdown    = r_countdown;
      w_p1_move      = r_p1_move;
      w_p2_move      = r_p2_move;
      w_result       = r_result;
      w_p1_score     = r_p1_score;
      w_p2_score     = r_p2_score;
      w_tmr_run      = r_tmr_run;
      w_tmr_target   = r_tmr_target;
      w_result_valid = 1'b0;
      w_match_over   = r_match_over;
      w_winner       = r_winner;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state      = COUNT;
               w_countdown  = c_cd_start;
               w_tmr_run    = 1'b1;
               w_tmr_target = c_count_tgt;
            end
         end

         COUNT: begin
            if (r_gap) begin
               w_tmr_run = 1'b1;
               if (r_countdown == 2'd1) begin
                  w_state      = CAPTURE;
                  w_countdown  = 2'd0;
                  w_tmr_target = c_window_tgt;
               end else begin
                  w_countdown = r_countdown - 2'd1;
               end
            end else if (w_hit) begin
               w_tmr_run = 1'b0;
               w_gap     = 1'b1;
            end
         end

         CAPTURE: begin
            if (r_gap) begin
               w_state = JUDGE;
            end else begin
               if (w_p1_take) w_p1_move = bus.p1_move;
               if (w_p2_take) w_p2_move = bus.p2_move;
               // Window closes early once both moves are in, otherwise on hit.
               if (((w_p1_move != NONE) && (w_p2_move != NONE)) || w_hit) begin
                  w_tmr_run = 1'b0;
                  w_gap     = 1'b1;
               end
            end
         end

         JUDGE: begin
            w_result = w_outcome;
            if (w_outcome == P1 && r_p1_score < c_win) w_p1_score = r_p1_score + 3'd1;
            if (w_outcome == P2 && r_p2_score < c_win) w_p2_score = r_p2_score + 3'd1;
            w_state        = SHOW;
            w_result_valid = 1'b1;
            w_tmr_run      = 1'b1;
            w_tmr_target   = c_result_tgt;
         end

         SHOW: begin
            if (r_gap) begin
               if (r_p1_score == c_win || r_p2_score == c_win) begin
                  w_state      = DONE;
                  w_match_over = 1'b1;
                  w_winner     = (r_p1_score == c_win) ? P1 : P2;
               end else begin
                  w_state      = COUNT;
                  w_countdown  = c_cd_start;
                  w_tmr_run    = 1'b1;
                  w_tmr_target = c_count_tgt;
                  w_p1_move    = NONE;
                  w_p2_move    = NONE;
               end
            end else if (w_hit) begin
               w_tmr_run = 1'b0;
               w_gap     = 1'b1;
            end
         end

         DONE: begin
            if (bus.start) begin
               w_state      = COUNT;
               w_countdown  = c_cd_start;
               w_tmr_run    = 1'b1;
               w_tmr_target = c_count_tgt;
               w_p1_move    = NONE;
               w_p2_move    = NONE;
               w_result     = TIE;
               w_p1_score   = 3'd0;
               w_p2_score   = 3'd0;
               w_match_over = 1'b0;
               w_winner     = TIE;
            end
         end

         default: begin
            w_state   = IDLE;
            w_tmr_run = 1'b0;
         end
      endcase
   end

   assign bus.tmr_run      = r_tmr_run;
   assign bus.tmr_target   = r_tmr_target;
   assign bus.state        = r_state;
   assign bus.countdown    = r_countdown;
   assign bus.p1_move_q    = r_p1_move;
   assign bus.p2_move_q    = r_p2_move;
   assign bus.round_result = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.p1_score     = r_p1_score;
   assign bus.p2_score     = r_p2_score;
   assign bus.match_over   = r_match_over;
   assign bus.match_winner = r_winner;

endmodule
`default_nettype wire
